// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encoding,
// stall/flush bit positions and the pipeline stage count.
package pipe_ctrl_pkg;

   typedef enum logic [0:0] {
      ST_RUN     = 1'b0,
      ST_MC_WAIT = 1'b1
   } state_e;

   localparam int NUM_STAGES = 5;
   localparam int NUM_FLUSH  = 3;

   // stall[] bit positions: each bit holds one pipeline register
   localparam int STALL_PC    = 0;
   localparam int STALL_IF_ID = 1;
   localparam int STALL_ID_EX = 2;
   localparam int STALL_EX_ME = 3;
   localparam int STALL_ME_WB = 4;

   // flush[] bit positions: each bit turns one pipeline register into a bubble
   localparam int FLUSH_IF_ID = 0;
   localparam int FLUSH_ID_EX = 1;
   localparam int FLUSH_EX_ME = 2;

endpackage

// File: rtl/pipe_hazard_det.sv
// Load-use hazard detector: the instruction in ID reads a register that
// the load currently in EX has not produced yet. x0 never creates a hazard.
module pipe_hazard_det (
   input  logic       id_rs1_re,
   input  logic [4:0] id_rs1_addr,
   input  logic       id_rs2_re,
   input  logic [4:0] id_rs2_addr,
   input  logic       ex_rd_we,
   input  logic [4:0] ex_rd_addr,
   input  logic       ex_is_load,
   output logic       hazard
);

   logic rs1_hit;
   logic rs2_hit;

   // Compare both ID source operands against the EX load destination
   always_comb begin
      rs1_hit = id_rs1_re && (id_rs1_addr == ex_rd_addr);
      rs2_hit = id_rs2_re && (id_rs2_addr == ex_rd_addr);
      hazard  = ex_is_load && ex_rd_we && (ex_rd_addr != 5'd0) && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch redirects,
// multi-cycle EX freezes, and a saturating stall-cycle counter.
// The FSM state is externally visible as mc_busy (1 exactly in MC_WAIT).
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MC_CNT_W = 6,
   parameter int PERF_W   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_rs1_re,
   input  logic [4:0]            id_rs1_addr,
   input  logic                  id_rs2_re,
   input  logic [4:0]            id_rs2_addr,
   input  logic                  ex_rd_we,
   input  logic [4:0]            ex_rd_addr,
   input  logic                  ex_is_load,
   input  logic                  ex_mc_start,
   input  logic [MC_CNT_W-1:0]   ex_mc_len,
   input  logic                  ex_br_taken,
   input  logic [31:0]           ex_br_target,
   output logic [NUM_STAGES-1:0] stall,
   output logic [NUM_FLUSH-1:0]  flush,
   output logic                  redirect_valid,
   output logic [31:0]           redirect_pc,
   output logic                  mc_busy,
   output logic                  mc_done,
   output logic [PERF_W-1:0]     stall_cycles
);

   state_e              state_q, state_d;
   logic [MC_CNT_W-1:0] cnt_q, cnt_d;
   logic [PERF_W-1:0]   perf_q, perf_d;
   logic                hazard;

   pipe_hazard_det u_hazard (
      .id_rs1_re   (id_rs1_re),
      .id_rs1_addr (id_rs1_addr),
      .id_rs2_re   (id_rs2_re),
      .id_rs2_addr (id_rs2_addr),
      .ex_rd_we    (ex_rd_we),
      .ex_rd_addr  (ex_rd_addr),
      .ex_is_load  (ex_is_load),
      .hazard      (hazard)
   );

   // Next state and control outputs; everything is forced quiet during reset
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      stall          = '0;
      flush          = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mc_busy        = 1'b0;
      mc_done        = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_RUN: begin
               if (ex_br_taken) begin
                  // A taken branch kills the wrong-path ID/IF instructions and
                  // overrides both a pending load-use stall and a multi-cycle start.
                  redirect_valid         = 1'b1;
                  redirect_pc            = ex_br_target;
                  flush[FLUSH_IF_ID]     = 1'b1;
                  flush[FLUSH_ID_EX]     = 1'b1;
               end else begin
                  if (hazard) begin
                     stall[STALL_PC]    = 1'b1;
                     stall[STALL_IF_ID] = 1'b1;
                     flush[FLUSH_ID_EX] = 1'b1;
                  end
                  if (ex_mc_start) begin
                     // Lengths 0 and 1 both give a single frozen cycle
                     state_d = ST_MC_WAIT;
                     cnt_d   = (ex_mc_len == '0) ? '0 : ex_mc_len - MC_CNT_W'(1);
                  end
               end
            end
            ST_MC_WAIT: begin
               // Freeze the front of the pipe and feed bubbles into EX_ME
               mc_busy            = 1'b1;
               stall[STALL_PC]    = 1'b1;
               stall[STALL_IF_ID] = 1'b1;
               stall[STALL_ID_EX] = 1'b1;
               flush[FLUSH_EX_ME] = 1'b1;
               if (cnt_q == '0) begin
                  mc_done = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  cnt_d = cnt_q - MC_CNT_W'(1);
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   // Saturating count of cycles in which the PC was held
   always_comb begin
      perf_d = perf_q;
      if (stall[STALL_PC] && (perf_q != {PERF_W{1'b1}})) begin
         perf_d = perf_q + PERF_W'(1);
      end
      stall_cycles = rst ? '0 : perf_q;
   end

   // State, multi-cycle counter and performance counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         perf_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         perf_q  <= perf_d;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. Expected output vectors are pushed to
// exp_q when stimulus is applied and popped at the following falling edge.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_rs1_re, id_rs2_re, ex_rd_we, ex_is_load;
   logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic        ex_mc_start, ex_br_taken;
   logic [5:0]  ex_mc_len;
   logic [31:0] ex_br_target;

   logic [4:0]  stall;
   logic [2:0]  flush;
   logic        redirect_valid, mc_busy, mc_done;
   logic [31:0] redirect_pc, stall_cycles;

   logic [4:0]  sat_stall;
   logic [2:0]  sat_flush;
   logic        sat_rv, sat_busy, sat_done;
   logic [31:0] sat_pc;
   logic [2:0]  sat_cycles;

   logic [42:0] exp_q[$];
   logic [42:0] exp_v;
   logic [42:0] obs;
   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] exp_perf     = 0;
   logic [2:0]  exp_sat      = 0;

   assign obs = {stall, flush, redirect_valid, redirect_pc, mc_busy, mc_done};

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk(clk), .rst(rst),
      .id_rs1_re(id_rs1_re), .id_rs1_addr(id_rs1_addr),
      .id_rs2_re(id_rs2_re), .id_rs2_addr(id_rs2_addr),
      .ex_rd_we(ex_rd_we), .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load),
      .ex_mc_start(ex_mc_start), .ex_mc_len(ex_mc_len),
      .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
      .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mc_busy(mc_busy), .mc_done(mc_done), .stall_cycles(stall_cycles)
   );

   // Narrow performance counter so saturation is reached by real counting
   pipe_ctrl #(.PERF_W(3)) u_sat (
      .clk(clk), .rst(rst),
      .id_rs1_re(id_rs1_re), .id_rs1_addr(id_rs1_addr),
      .id_rs2_re(id_rs2_re), .id_rs2_addr(id_rs2_addr),
      .ex_rd_we(ex_rd_we), .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load),
      .ex_mc_start(ex_mc_start), .ex_mc_len(ex_mc_len),
      .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
      .stall(sat_stall), .flush(sat_flush),
      .redirect_valid(sat_rv), .redirect_pc(sat_pc),
      .mc_busy(sat_busy), .mc_done(sat_done), .stall_cycles(sat_cycles)
   );

   function automatic logic [42:0] mk(input logic [4:0] s, input logic [2:0] f,
                                      input logic rv, input logic [31:0] pc,
                                      input logic b, input logic d);
      return {s, f, rv, pc, b, d};
   endfunction

   task automatic idle_inputs();
      id_rs1_re = 0; id_rs1_addr = 0; id_rs2_re = 0; id_rs2_addr = 0;
      ex_rd_we = 0; ex_rd_addr = 0; ex_is_load = 0;
      ex_mc_start = 0; ex_mc_len = 0; ex_br_taken = 0; ex_br_target = 0;
   endtask

   // Everything that should be ignored while frozen or in reset
   task automatic noisy_inputs();
      ex_br_taken = 1; ex_br_target = $urandom;
      ex_is_load = 1; ex_rd_we = 1; ex_rd_addr = 5'd7;
      id_rs1_re = 1; id_rs1_addr = 5'd7;
      ex_mc_start = 1; ex_mc_len = 6'($urandom_range(0, 63));
   endtask

   task automatic test_reset();
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         noisy_inputs();
         exp_q.push_back('0);
         @(negedge clk);
         exp_v = exp_q.pop_front();
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected %h", obs, exp_v);
         end
         tests_run++;
         if (stall_cycles !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_perf: got %0d expected 0", stall_cycles);
         end
         @(posedge clk); #1;
      end
      rst = 0;
      idle_inputs();
   endtask

   task automatic test_load_use();
      logic hz;
      logic [4:0] a;
      for (int i = 0; i < 26; i++) begin
         idle_inputs();
         a = 5'($urandom_range(1, 31));
         case (i)
            0: begin ex_is_load = 1; ex_rd_we = 1; ex_rd_addr = 5; id_rs2_re = 1; id_rs2_addr = 5; end
            1: begin ex_is_load = 1; ex_rd_we = 1; ex_rd_addr = 0; id_rs2_re = 1; id_rs2_addr = 0; end
            2: begin ex_is_load = 1; ex_rd_we = 1; ex_rd_addr = 5; id_rs2_re = 0; id_rs2_addr = 5; end
            3: begin ex_is_load = 1; ex_rd_we = 1; ex_rd_addr = a; id_rs1_re = 1; id_rs1_addr = a; end
            4: begin ex_is_load = 0; ex_rd_we = 1; ex_rd_addr = a; id_rs1_re = 1; id_rs1_addr = a; end
            5: begin ex_is_load = 1; ex_rd_we = 0; ex_rd_addr = a; id_rs2_re = 1; id_rs2_addr = a; end
            default: begin
               ex_is_load = 1'($urandom); ex_rd_we = 1'($urandom);
               ex_rd_addr = 5'($urandom_range(0, 3));
               id_rs1_re = 1'($urandom); id_rs1_addr = 5'($urandom_range(0, 3));
               id_rs2_re = 1'($urandom); id_rs2_addr = 5'($urandom_range(0, 3));
            end
         endcase
         hz = ex_is_load && ex_rd_we && (ex_rd_addr != 0) &&
              ((id_rs1_re && id_rs1_addr == ex_rd_addr) || (id_rs2_re && id_rs2_addr == ex_rd_addr));
         exp_q.push_back(hz ? mk(5'b00011, 3'b010, 0, 0, 0, 0) : '0);
         if (hz) exp_perf++;
         @(negedge clk);
         exp_v = exp_q.pop_front();
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL load_use[%0d]: got %h expected %h", i, obs, exp_v);
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      @(negedge clk);
      tests_run++;
      if (stall_cycles !== exp_perf) begin
         tests_failed++;
         $display("FAIL load_use_perf: got %0d expected %0d", stall_cycles, exp_perf);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_branch();
      logic [31:0] t;
      for (int i = 0; i < 4; i++) begin
         idle_inputs();
         t = $urandom;
         case (i)
            0: begin
               ex_br_taken = 1; ex_br_target = 32'h0000_0100;
               ex_is_load = 1; ex_rd_we = 1; ex_rd_addr = 5; id_rs2_re = 1; id_rs2_addr = 5;
               exp_q.push_back(mk(5'b00000, 3'b011, 1, 32'h100, 0, 0));
            end
            1: begin
               ex_br_taken = 1; ex_br_target = t; ex_mc_start = 1; ex_mc_len = 4;
               exp_q.push_back(mk(5'b00000, 3'b011, 1, t, 0, 0));
            end
            2: exp_q.push_back('0); // multi-cycle start was dropped: still RUN
            default: begin
               ex_br_taken = 0; ex_br_target = t;
               exp_q.push_back('0);
            end
         endcase
         @(negedge clk);
         exp_v = exp_q.pop_front();
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL branch[%0d]: got %h expected %h", i, obs, exp_v);
         end
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   task automatic test_multicycle(input int len, input bit noisy);
      int n;
      n = (len == 0) ? 1 : len;
      idle_inputs();
      ex_mc_start = 1; ex_mc_len = 6'(len);
      exp_q.push_back('0);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL mc_start len%0d: got %h expected %h", len, obs, exp_v);
      end
      @(posedge clk); #1;
      for (int k = 0; k < n; k++) begin
         idle_inputs();
         if (noisy) noisy_inputs();
         exp_q.push_back(mk(5'b00111, 3'b100, 0, 0, 1, (k == n - 1)));
         exp_perf++;
         @(negedge clk);
         exp_v = exp_q.pop_front();
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL mc_wait len%0d cyc%0d: got %h expected %h", len, k, obs, exp_v);
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      exp_q.push_back('0);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL mc_after len%0d: got %h expected %h", len, obs, exp_v);
      end
      tests_run++;
      if (stall_cycles !== exp_perf) begin
         tests_failed++;
         $display("FAIL mc_perf len%0d: got %0d expected %0d", len, stall_cycles, exp_perf);
      end
      @(posedge clk); #1;
   endtask

   // Second op starts in the very RUN cycle after the first finishes
   task automatic test_back_to_back();
      for (int i = 0; i < 7; i++) begin
         idle_inputs();
         case (i)
            0: begin ex_mc_start = 1; ex_mc_len = 2; exp_q.push_back('0); end
            1: exp_q.push_back(mk(5'b00111, 3'b100, 0, 0, 1, 0));
            2: exp_q.push_back(mk(5'b00111, 3'b100, 0, 0, 1, 1));
            3: begin ex_mc_start = 1; ex_mc_len = 3; exp_q.push_back('0); end
            4: exp_q.push_back(mk(5'b00111, 3'b100, 0, 0, 1, 0));
            5: exp_q.push_back(mk(5'b00111, 3'b100, 0, 0, 1, 0));
            default: exp_q.push_back(mk(5'b00111, 3'b100, 0, 0, 1, 1));
         endcase
         if (i != 0 && i != 3) exp_perf++;
         @(negedge clk);
         exp_v = exp_q.pop_front();
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, exp_v);
         end
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   task automatic test_reset_abort();
      for (int i = 0; i < 7; i++) begin
         idle_inputs();
         rst = 0;
         case (i)
            0: begin ex_mc_start = 1; ex_mc_len = 10; exp_q.push_back('0); end
            1, 2: exp_q.push_back(mk(5'b00111, 3'b100, 0, 0, 1, 0));
            3: begin rst = 1; noisy_inputs(); exp_q.push_back('0); end
            default: exp_q.push_back('0);
         endcase
         @(negedge clk);
         exp_v = exp_q.pop_front();
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_abort[%0d]: got %h expected %h", i, obs, exp_v);
         end
         if (i >= 3) begin
            tests_run++;
            if (stall_cycles !== 32'd0) begin
               tests_failed++;
               $display("FAIL reset_abort_perf[%0d]: got %0d expected 0", i, stall_cycles);
            end
         end
         @(posedge clk); #1;
      end
      rst = 0;
      idle_inputs();
      exp_perf = 0;
      exp_sat  = 0;
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 10; i++) begin
         idle_inputs();
         ex_is_load = 1; ex_rd_we = 1; ex_rd_addr = 9; id_rs1_re = 1; id_rs1_addr = 9;
         exp_q.push_back(mk(5'b00011, 3'b010, 0, 0, 0, 0));
         @(negedge clk);
         exp_v = exp_q.pop_front();
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL sat_stall[%0d]: got %h expected %h", i, obs, exp_v);
         end
         tests_run++;
         if (sat_cycles !== exp_sat) begin
            tests_failed++;
            $display("FAIL sat_count[%0d]: got %0d expected %0d", i, sat_cycles, exp_sat);
         end
         tests_run++;
         if (stall_cycles !== exp_perf) begin
            tests_failed++;
            $display("FAIL sat_wide_count[%0d]: got %0d expected %0d", i, stall_cycles, exp_perf);
         end
         exp_perf++;
         if (exp_sat != 3'b111) exp_sat++;
         @(posedge clk); #1;
      end
      idle_inputs();
      @(negedge clk);
      tests_run++;
      if (sat_cycles !== 3'b111) begin
         tests_failed++;
         $display("FAIL sat_final: got %0d expected 7", sat_cycles);
      end
      tests_run++;
      if (stall_cycles !== exp_perf) begin
         tests_failed++;
         $display("FAIL sat_wide_final: got %0d expected %0d", stall_cycles, exp_perf);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      test_reset();
      test_load_use();
      test_branch();
      test_multicycle(4, 0);
      test_multicycle(0, 0);
      test_multicycle(1, 0);
      test_multicycle(5, 1);
      test_multicycle(63, 0);
      test_back_to_back();
      test_reset_abort();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MC_CNT_W, default 6, width of the multi-cycle length field and down-counter.
REQ-002 SHALL have parameter PERF_W, default 32, width of the stall-cycle performance counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port id_rs1_re / id_rs1_addr, input, 1/5, ID stage rs1 read enable and address.
REQ-006 SHALL have port id_rs2_re / id_rs2_addr, input, 1/5, ID stage rs2 read enable and address.
REQ-007 SHALL have port ex_rd_we / ex_rd_addr / ex_is_load, input, 1/5/1, destination of the instruction in EX and whether it is a load.
REQ-008 SHALL have port ex_mc_start / ex_mc_len, input, 1/MC_CNT_W, EX starts a multi-cycle op of ex_mc_len cycles.
REQ-009 SHALL have port ex_br_taken / ex_br_target, input, 1/32, taken branch or jump resolved in EX, with its target.
REQ-010 SHALL have port stall, output, 5, per-stage hold: bit0 PC, bit1 IF_ID, bit2 ID_EX, bit3 EX_ME, bit4 ME_WB.
REQ-011 SHALL have port flush, output, 3, bubble insert: bit0 IF_ID, bit1 ID_EX, bit2 EX_ME.
REQ-012 SHALL have port redirect_valid / redirect_pc, output, 1/32, PC redirect request.
REQ-013 SHALL have ports mc_busy / mc_done / stall_cycles, output, 1/1/PERF_W: multi-cycle active, 1-cycle completion pulse, performance count.

Function
REQ-014 SHALL implement FSM states RUN and MC_WAIT.
REQ-015 Load-use, RUN only: ex_is_load & ex_rd_we & ex_rd_addr!=0 & ((id_rs1_re & rs1 match) | (id_rs2_re & rs2 match)) SHALL assert stall[1:0] and flush[1] that same cycle (combinational).
REQ-016 Branch, RUN only: ex_br_taken SHALL assert redirect_valid, redirect_pc=ex_br_target, and flush[1:0] the same cycle.
REQ-017 Branch SHALL take priority over load-use in the same cycle: no stall, flush[1:0] only.
REQ-018 Multi-cycle: ex_mc_start in RUN SHALL enter MC_WAIT next cycle and load the counter with max(ex_mc_len,1)-1.
REQ-019 ex_mc_start together with ex_br_taken SHALL be ignored; the branch wins.
REQ-020 In MC_WAIT, stall[2:0] and flush[2] SHALL be 1 every cycle, and the counter SHALL decrement each cycle.
REQ-021 In MC_WAIT with counter 0, mc_done SHALL pulse for 1 cycle and the FSM SHALL return to RUN next cycle.
REQ-022 Total freeze for len N SHALL be N cycles after the start cycle; len 0 and len 1 SHALL both give 1.
REQ-023 In MC_WAIT, ex_mc_start, ex_br_taken and load-use SHALL be ignored.
REQ-024 mc_busy SHALL equal (state==MC_WAIT).
REQ-025 stall[4:3] SHALL always be 0.
REQ-026 redirect_pc SHALL be 0 when redirect_valid is 0.
REQ-027 stall_cycles SHALL increment on every cycle where stall[0]=1, saturating at all-ones.

Reset
REQ-028 On rst=1 at a clock edge: state RUN, counter 0, stall_cycles 0.
REQ-029 All outputs SHALL be 0 while rst=1, including combinational ones.
REQ-030 Reset during MC_WAIT SHALL abort the op with no mc_done pulse.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, stall/flush bit-index constants, and stage count 5.
REQ-032 Load-use comparison SHALL be a combinational sub-module pipe_hazard_det (inputs: the ID and EX ports; output: hazard).
REQ-033 The remaining sequencing logic SHALL live in pipe_ctrl with no memories.

Verification
REQ-034 RUN, ex_is_load=1, ex_rd_we=1, ex_rd_addr=5, id_rs2_re=1, id_rs2_addr=5 -> stall=5'b00011, flush=3'b010 for 1 cycle, stall_cycles +1.
REQ-035 Same as REQ-034 with ex_rd_addr=0, or with id_rs2_re=0 -> stall=0, flush=0.
REQ-036 ex_br_taken=1, target 0x0000_0100, load-use also true -> redirect_valid=1, redirect_pc=0x100, flush=3'b011, stall=0.
REQ-037 ex_mc_start with len 4 -> mc_busy high for 4 cycles, stall=5'b00111 and flush[2]=1 in those cycles, mc_done on the 4th, RUN after; len 0 -> 1 cycle.
REQ-038 rst asserted 2 cycles into a len-10 op -> next cycle state RUN, all outputs 0, no mc_done.
REQ-039 stall_cycles preloaded near all-ones by forcing, then 3 stall cycles -> holds at all-ones.
